// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a registered IDLE/GRANT FSM.
// One requester owns the grant until it drops its request. The grant is
// presented both as a binary index (gnt_idx) and as its one-hot decode (gnt).
// There is always one idle cycle between two grants.
//
// Optional feature: define ARB_TIMEOUT_EN to compile in a hold timeout. With it,
// a grant held for MAX_HOLD cycles is revoked. timeout pulses for one cycle, and
// the revoked requester is skipped in the next arbitration only.
// Without it, timeout is tied low and grants last indefinitely.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [2:0] ptr_reg;      // highest-priority index for the next arbitration
    logic [7:0] cand;         // requests eligible in the current arbitration
    logic       found;
    logic [2:0] sel_idx;
    logic [7:0] sel_onehot;

    // MAX_HOLD only matters with the timeout, but a bad value is rejected in every build
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be in 2..255");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_reg; // GRANT cycles elapsed for the current owner
    logic [7:0] mask_reg;     // one-hot of a just-revoked owner, cleared after one IDLE cycle

    assign cand = req & ~mask_reg;
`else
    assign cand    = req;
    assign timeout = 1'b0;
`endif

    // Rotating priority search: the first eligible bit at or after ptr_reg, wrapping 7->0.
    // The loop runs from the farthest offset down, so the nearest hit wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = ptr_reg;
        for (int i = 7; i >= 0; i--) begin
            if (cand[3'(ptr_reg + 3'(i))]) begin
                found   = 1'b1;
                sel_idx = 3'(ptr_reg + 3'(i));
            end
        end
    end

    // Each bit of the one-hot grant is simply an equality with the selected index
    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
        assign sel_onehot[gi] = (sel_idx == 3'(gi));
    end

    // Grant FSM. All outputs are registered here, and gnt is always loaded as the
    // decode of the same index that goes into gnt_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= 3'd0;
            gnt          <= 8'h00;
            gnt_idx      <= 3'd0;
            gnt_valid    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg <= 8'd0;
            mask_reg     <= 8'h00;
            timeout      <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    // The revoke mask applies to exactly one arbitration, even an empty one
                    mask_reg <= 8'h00;
`endif
                    if (found) begin
                        state_reg <= GRANT;
                        gnt_idx   <= sel_idx;
                        gnt       <= sel_onehot;
                        gnt_valid <= 1'b1;
                        ptr_reg   <= sel_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_reg <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[gnt_idx]) begin
                        state_reg <= IDLE;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg <= IDLE;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                        mask_reg  <= gnt;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench for rr_arbiter8. The stimulus process drives
// req at the falling edge and steps a behavioural model (owner, pointer, hold
// age) to predict what the next rising edge produces. It pushes that prediction
// into a queue. A separate monitor pops one prediction after each rising edge
// and compares it with the DUT outputs. Directed sequences add fixed
// expectations, and the asynchronous reset is checked directly between edges.
module tb_rr_arbiter8;

    localparam int TB_MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // Behavioural model state: owner -1 means idle.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_mask  = -1;
    int m_to    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_mask  = -1;
        m_to    = 0;
    endfunction

    // What one rising edge does, given the request vector sampled at it.
    function automatic void model_edge(input logic [7:0] r);
        int pick;
        m_to = 0;
        if (m_owner < 0) begin
            pick = -1;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (pick < 0 && r[c] && c != m_mask) pick = c;
            end
            m_mask = -1;
            if (pick >= 0) begin
                m_owner = pick;
                m_ptr   = (pick + 1) % 8;
                m_hold  = 0;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (TIMEOUT_ON && m_hold == TB_MAX_HOLD - 1) begin
            m_mask  = m_owner;
            m_owner = -1;
            m_to    = 1;
        end else begin
            m_hold++;
        end
    endfunction

    // Called at a falling edge; returns at the following falling edge.
    task automatic step(input logic [7:0] r);
        exp_t e;
        req = r;
        model_edge(r);
        e.valid = (m_owner >= 0);
        e.gnt   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        e.idx   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e.to    = 1'(m_to);
        e.cyc   = cyc_no;
        cyc_no++;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge; holds reset for two cycles and releases at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h00);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        rst_n = 1'b1;
    endtask

    // Monitor: one prediction per rising edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("c%0d_gnt", e.cyc), 32'(gnt), 32'(e.gnt));
                chk($sformatf("c%0d_valid", e.cyc), 32'(gnt_valid), 32'(e.valid));
                chk($sformatf("c%0d_timeout", e.cyc), 32'(timeout), 32'(e.to));
                if (e.valid) chk($sformatf("c%0d_idx", e.cyc), 32'(gnt_idx), 32'(e.idx));
            end
        end
    end

    // Watchdog: the stimulus is a fixed number of cycles, so this should never fire.
    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;
        rst_n = 1'b0;
        req   = 8'h00;
        @(negedge clk);

        // Reset with every requester active; the first edge after release grants 0
        do_reset();
        step(8'hFF);
        chk("first_gnt", 32'(gnt), 32'h01);
        chk("first_idx", 32'(gnt_idx), 32'h0);

        // Rotation: each owner holds two cycles and then drops its bit for one cycle
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                step(8'hFF);
                chk($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(8'h01 << (k % 8)));
            end
            step(8'hFF);
            step(8'hFF & ~(8'h01 << (k % 8)));
            chk($sformatf("rot%0d_idle", k), 32'(gnt_valid), 32'h0);
        end

        // Wrap and skip: grant 5 sets ptr to 6, then 0 and 1 follow, and 7 comes after 1
        do_reset();
        step(8'h20);
        chk("wrap_g5", 32'(gnt), 32'h20);
        step(8'h20);
        step(8'h03);
        step(8'h03);
        chk("wrap_g0", 32'(gnt), 32'h01);
        step(8'h83);
        step(8'h82);
        step(8'h82);
        chk("wrap_g1", 32'(gnt), 32'h02);
        step(8'h82);
        step(8'h80);
        step(8'h80);
        chk("wrap_g7", 32'(gnt), 32'h80);
        step(8'h00);
        step(8'h00);

`ifndef ARB_TIMEOUT_EN
        // Hold and ignore: 3 keeps the grant for 40 cycles against full contention
        do_reset();
        step(8'h04);
        step(8'h00);
        for (int k = 0; k < 40; k++) begin
            step(8'hFF);
            if (k == 0 || k == 39) chk($sformatf("hold_c%0d", k), 32'(gnt), 32'h08);
        end
        step(8'hF7);
        chk("hold_idle", 32'(gnt_valid), 32'h0);
        step(8'hFF);
        chk("hold_next4", 32'(gnt), 32'h10);
        step(8'h00);
        step(8'h00);
`else
        // Timeout: 2 never releases; it is revoked after four cycles, then 5 is served
        do_reset();
        step(8'h02);
        step(8'h00);
        step(8'h00);
        for (int k = 0; k < 4; k++) begin
            step(8'h24);
            chk($sformatf("to_hold%0d", k), 32'(gnt), 32'h04);
        end
        step(8'h24);
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_revoked", 32'(gnt), 32'h00);
        step(8'h24);
        chk("to_g5", 32'(gnt), 32'h20);
        chk("to_pulse_end", 32'(timeout), 32'h0);
        step(8'h04);
        step(8'h04);
        chk("to_g2_again", 32'(gnt), 32'h04);
        repeat (3) step(8'h04);
        step(8'h04);
        chk("to_pulse2", 32'(timeout), 32'h1);
        step(8'h04);
        chk("to_masked_idle", 32'(gnt_valid), 32'h0);
        step(8'h04);
        chk("to_regrant2", 32'(gnt), 32'h04);
        step(8'h00);
        step(8'h00);
`endif

        // Asynchronous reset mid-grant: outputs clear between clock edges
        do_reset();
        step(8'h10);
        chk("ar_g4", 32'(gnt), 32'h10);
        step(8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt_now", 32'(gnt), 32'h00);
        chk("ar_valid_now", 32'(gnt_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'hFF);
        chk("ar_restart0", 32'(gnt), 32'h01);

        // Random traffic; the owner usually keeps its bit high
        for (int k = 0; k < 400; k++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            step(r);
        end

        // The monitor has consumed every prediction by now
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one CPU-side resource (bus, memory port, or register-file write port) among eight requesters. A registered FSM grants one requester at a time and holds the grant until that requester releases. The grant is produced as a 3-bit index and as a one-hot 8-bit vector decoded from it, so downstream muxes and enables need no further decoding. An optional hold-timeout revokes a grant that is held too long.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one owner may hold the grant. Used only with timeout compiled in. Legal range 2..255.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  8  request per requester. Must stay high for the whole ownership.
- gnt  output  8  one-hot grant, registered, all-zero when idle
- gnt_idx  output  3  binary index of the owner. Valid only while gnt_valid=1.
- gnt_valid  output  1  high while any grant is active
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- State machine: IDLE, GRANT.
- **IDLE**
  - If req≠0, select the first set bit at or after ptr, searching upward and wrapping 7→0.
  - Load gnt_idx with that index, set gnt to the decoded one-hot, set gnt_valid=1, go to GRANT.
  - ptr = selected+1 (mod 8).
- **GRANT**
  - Stay in GRANT while req[gnt_idx]=1.
  - When req[gnt_idx]=0 is sampled, go to IDLE: gnt=0, gnt_valid=0.
  - gnt_idx holds its last value while idle. It is don't-care, but must not be X after reset.
- Requests from non-owners have no effect during GRANT.
- ptr is a 3-bit register and wraps naturally.
- gnt is always exactly the one-hot decode of gnt_idx while gnt_valid=1, and all-zero otherwise.
- Reset mid-grant forces IDLE immediately; the owner's req is not acknowledged.
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, ptr=3'd0, state=IDLE, hold counter=0.

## Timing
- Request to grant: req sampled at edge N gives gnt at edge N (registered output), visible in cycle N+1. Latency is 1 cycle from IDLE.
- Release to idle: req[owner] low at edge N gives gnt=0 after edge N.
- Re-arbitration needs at least one IDLE cycle, so there is one dead cycle between any two grants, including back-to-back grants to different requesters.
- A requester that drops req and re-raises it within the dead cycle competes normally. Its priority is lowest because ptr has already advanced past it.
- All outputs change only on rising clk edges or on asynchronous reset assertion. Reset release is synchronous to clk.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 with req[owner] still high, the next edge forces IDLE: gnt=0, gnt_valid=0, timeout=1 for exactly one cycle.
  - The revoked index is masked out of the following single arbitration only.
  - If the revoked requester is the only one requesting, the arbiter stays IDLE for one extra cycle, then re-grants it.
- ARB_TIMEOUT_EN undefined:
  - No counter logic.
  - timeout is tied to 0.
  - Grants last indefinitely.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF, then release. Before the first edge: gnt=0, gnt_valid=0, timeout=0. After the first edge: gnt=8'h01, gnt_idx=0.
- Rotation: req=8'hFF, with each owner dropping its req bit for one cycle after 2 grant cycles. Grants go 0,1,2,…,7,0, each separated by exactly one idle cycle.
- Wrap and skip: ptr=6 (after a grant to 5), req=8'b0000_0011. Grant goes to 0, then to 1. Requester 7 raised during 0's grant is served after 1.
- Hold and ignore: owner 3 holds req for 40 cycles while req=8'hFF (timeout compiled out). gnt stays 8'h08 for 40 cycles, then IDLE, then grant goes to 4.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): owner 2 never releases, req=8'h24. After 4 GRANT cycles: timeout pulses once, one idle cycle, then grant goes to 5. With req=8'h04 only: two idle cycles, then re-grant to 2.
- Async reset mid-grant: assert rst_n low between edges while gnt=8'h10. gnt=0 and gnt_valid=0 immediately, without waiting for a clock edge. After release, arbitration restarts from ptr=0.
